// File: rtl/axi4lite_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | axi4lite_pkg : shared constants, FSM state types, helper function |
// | Revision     : 1.0                                                |
// +-------------------------------------------------------------------+
package axi4lite_pkg;

   localparam logic [1:0]  RESP_OKAY            = 2'b00;
   localparam logic [1:0]  RESP_SLVERR          = 2'b10;
   localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h1000_0000;

   typedef enum logic [0:0] {
      WR_IDLE = 1'b0,
      WR_RESP = 1'b1
   } wr_state_e;

   typedef enum logic [0:0] {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } rd_state_e;

   // Add up to two error events to an 8-bit count, clamping at 255.
   function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, base} + {7'b0, inc};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi4lite_mem_slave_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | axi4lite_mem_slave_if : AXI4-Lite bus bundle with modports        |
// | Revision              : 1.0                                       |
// +-------------------------------------------------------------------+
interface axi4lite_mem_slave_if;

   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [2:0]  awprot;

   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;

   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;

   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [2:0]  arprot;

   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

endinterface
`default_nettype wire

// File: rtl/mem_bytewise_sp.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mem_bytewise_sp : 32-bit RAM, byte-enabled write, registered read |
// | Revision        : 1.0                                             |
// +-------------------------------------------------------------------+
module mem_bytewise_sp #(
   parameter int WORDS = 16384,
   parameter int IDX_W = $clog2(WORDS)
) (
   input  wire logic             clk,
   input  wire logic             we,
   input  wire logic [3:0]       wbe,
   input  wire logic [IDX_W-1:0] waddr,
   input  wire logic [31:0]      wdata,
   input  wire logic             re,
   input  wire logic [IDX_W-1:0] raddr,
   output      logic [31:0]      rdata
);

   // One array per byte lane keeps each write enable independent; a read
   // and write to the same word in one cycle returns the old contents.
   for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [7:0] lane_mem [WORDS];
      logic [7:0] rd_byte_q;

      always_ff @(posedge clk) begin
         if (we && wbe[i]) begin
            lane_mem[waddr] <= wdata[8*i +: 8];
         end
         if (re) begin
            rd_byte_q <= lane_mem[raddr];
         end
      end

      assign rdata[8*i +: 8] = rd_byte_q;
   end

endmodule
`default_nettype wire

// File: rtl/axi4lite_mem_slave.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | axi4lite_mem_slave : AXI4-Lite RAM slave with write-only console  |
// | Revision           : 1.0                                          |
// +-------------------------------------------------------------------+
module axi4lite_mem_slave
   import axi4lite_pkg::*;
#(
   parameter int          MEM_WORDS    = 16384,
   parameter logic [31:0] CONSOLE_ADDR = DEFAULT_CONSOLE_ADDR
) (
   input  wire logic            clk,
   input  wire logic            resetn,
   axi4lite_mem_slave_if.slave  s,
   output      logic            console_valid,
   output      logic [7:0]      console_data,
   output      logic [7:0]      err_count
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   wr_state_e   wr_state_q, wr_state_d;
   logic        aw_full_q, aw_full_d;
   logic [31:0] aw_addr_q, aw_addr_d;
   logic        w_full_q, w_full_d;
   logic [31:0] w_data_q, w_data_d;
   logic [3:0]  w_strb_q, w_strb_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        console_valid_q, console_valid_d;
   logic [7:0]  console_data_q, console_data_d;

   rd_state_e   rd_state_q, rd_state_d;
   logic        rd_ok_q, rd_ok_d;
   logic [1:0]  rresp_q, rresp_d;

   logic [7:0]  err_count_q, err_count_d;

   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata;
   logic        wr_err;
   logic        rd_err;
   logic        wr_in_range;
   logic        wr_is_console;
   logic        rd_ok;
   logic        unused_prot;

   assign wr_in_range   = (aw_addr_q[31:2] < 30'(MEM_WORDS));
   assign wr_is_console = (aw_addr_q == CONSOLE_ADDR);
   assign rd_ok         = (s.araddr[31:2] < 30'(MEM_WORDS)) && (s.araddr != CONSOLE_ADDR);
   assign unused_prot   = ^{s.awprot, s.arprot};

   always_comb begin
      wr_state_d      = wr_state_q;
      aw_full_d       = aw_full_q;
      aw_addr_d       = aw_addr_q;
      w_full_d        = w_full_q;
      w_data_d        = w_data_q;
      w_strb_d        = w_strb_q;
      bresp_d         = bresp_q;
      console_valid_d = 1'b0;
      console_data_d  = console_data_q;
      mem_we          = 1'b0;
      wr_err          = 1'b0;

      if (s.awvalid && !aw_full_q) begin
         aw_full_d = 1'b1;
         aw_addr_d = s.awaddr;
      end
      if (s.wvalid && !w_full_q) begin
         w_full_d = 1'b1;
         w_data_d = s.wdata;
         w_strb_d = s.wstrb;
      end

      case (wr_state_q)
         WR_IDLE: begin
            if (aw_full_q && w_full_q) begin
               wr_state_d = WR_RESP;
               // Console decode wins so the console never aliases RAM.
               if (wr_is_console) begin
                  console_valid_d = 1'b1;
                  console_data_d  = w_data_q[7:0];
                  bresp_d         = RESP_OKAY;
               end else if (wr_in_range) begin
                  mem_we  = 1'b1;
                  bresp_d = RESP_OKAY;
               end else begin
                  bresp_d = RESP_SLVERR;
                  wr_err  = 1'b1;
               end
            end
         end
         WR_RESP: begin
            if (s.bready) begin
               wr_state_d = WR_IDLE;
               aw_full_d  = 1'b0;
               w_full_d   = 1'b0;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rd_ok_d    = rd_ok_q;
      rresp_d    = rresp_q;
      mem_re     = 1'b0;
      rd_err     = 1'b0;

      case (rd_state_q)
         RD_IDLE: begin
            if (s.arvalid) begin
               rd_state_d = RD_DATA;
               mem_re     = rd_ok;
               rd_ok_d    = rd_ok;
               rresp_d    = rd_ok ? RESP_OKAY : RESP_SLVERR;
               rd_err     = !rd_ok;
            end
         end
         RD_DATA: begin
            if (s.rready) begin
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      err_count_d = sat_add8(err_count_q, {1'b0, wr_err} + {1'b0, rd_err});
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_state_q      <= WR_IDLE;
         aw_full_q       <= 1'b0;
         aw_addr_q       <= '0;
         w_full_q        <= 1'b0;
         w_data_q        <= '0;
         w_strb_q        <= '0;
         bresp_q         <= RESP_OKAY;
         console_valid_q <= 1'b0;
         console_data_q  <= '0;
         rd_state_q      <= RD_IDLE;
         rd_ok_q         <= 1'b0;
         rresp_q         <= RESP_OKAY;
         err_count_q     <= '0;
      end else begin
         wr_state_q      <= wr_state_d;
         aw_full_q       <= aw_full_d;
         aw_addr_q       <= aw_addr_d;
         w_full_q        <= w_full_d;
         w_data_q        <= w_data_d;
         w_strb_q        <= w_strb_d;
         bresp_q         <= bresp_d;
         console_valid_q <= console_valid_d;
         console_data_q  <= console_data_d;
         rd_state_q      <= rd_state_d;
         rd_ok_q         <= rd_ok_d;
         rresp_q         <= rresp_d;
         err_count_q     <= err_count_d;
      end
   end

   mem_bytewise_sp #(
      .WORDS (MEM_WORDS),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .wbe   (w_strb_q),
      .waddr (aw_addr_q[IDX_W+1:2]),
      .wdata (w_data_q),
      .re    (mem_re),
      .raddr (s.araddr[IDX_W+1:2]),
      .rdata (mem_rdata)
   );

   assign s.awready     = !aw_full_q;
   assign s.wready      = !w_full_q;
   assign s.bvalid      = (wr_state_q == WR_RESP);
   assign s.bresp       = bresp_q;
   assign s.arready     = (rd_state_q == RD_IDLE);
   assign s.rvalid      = (rd_state_q == RD_DATA);
   assign s.rresp       = rresp_q;
   // RAM output is masked so failed reads and post-reset reads show zero.
   assign s.rdata       = rd_ok_q ? mem_rdata : 32'h0;
   assign console_valid = console_valid_q;
   assign console_data  = console_data_q;
   assign err_count     = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_mem_slave.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_axi4lite_mem_slave : directed bench for axi4lite_mem_slave     |
// | Revision              : 1.0                                       |
// +-------------------------------------------------------------------+
module tb_axi4lite_mem_slave;
   import axi4lite_pkg::*;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       console_valid;
   logic [7:0] console_data;
   logic [7:0] err_count;
   int         checks = 0;
   int         errors = 0;

   axi4lite_mem_slave_if bus ();

   axi4lite_mem_slave #(
      .MEM_WORDS    (16384),
      .CONSOLE_ADDR (32'h1000_0000)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .s             (bus.slave),
      .console_valid (console_valid),
      .console_data  (console_data),
      .err_count     (err_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present AW and W together, wait for both handshakes, then for bvalid.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int  n;
      logic aw_hs, w_hs;
      bus.awvalid = 1'b1; bus.awaddr = addr;
      bus.wvalid  = 1'b1; bus.wdata  = data; bus.wstrb = strb;
      n = 0;
      while ((bus.awvalid || bus.wvalid) && n < 20) begin
         aw_hs = bus.awvalid && bus.awready;
         w_hs  = bus.wvalid && bus.wready;
         tick();
         if (aw_hs) bus.awvalid = 1'b0;
         if (w_hs)  bus.wvalid  = 1'b0;
         n++;
      end
      chk("wr_accept_timeout", {31'b0, bus.awvalid | bus.wvalid}, 32'd0);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      n = 0;
      while (!bus.bvalid && n < 20) begin
         tick();
         n++;
      end
      chk("bvalid_seen", {31'b0, bus.bvalid}, 32'd1);
   endtask

   task automatic ack_b();
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      chk("bvalid_after_ack", {31'b0, bus.bvalid}, 32'd0);
      chk("awready_after_ack", {31'b0, bus.awready}, 32'd1);
      chk("wready_after_ack", {31'b0, bus.wready}, 32'd1);
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
      int n;
      bus.arvalid = 1'b1; bus.araddr = addr;
      n = 0;
      while (!bus.arready && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_arready"}, {31'b0, bus.arready}, 32'd1);
      tick();
      bus.arvalid = 1'b0;
      chk({tag, "_rvalid"}, {31'b0, bus.rvalid}, 32'd1);
      chk({tag, "_rdata"}, bus.rdata, exp_data);
      chk({tag, "_rresp"}, {30'b0, bus.rresp}, {30'b0, exp_resp});
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
      chk({tag, "_rvalid_clr"}, {31'b0, bus.rvalid}, 32'd0);
   endtask

   initial begin
      bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
      bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
      bus.bready  = 1'b0;
      bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0;
      bus.rready  = 1'b0;

      #2 resetn = 1'b0;
      tick(); tick();
      chk("rst_bvalid", {31'b0, bus.bvalid}, 32'd0);
      chk("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
      chk("rst_console_valid", {31'b0, console_valid}, 32'd0);
      chk("rst_console_data", {24'b0, console_data}, 32'd0);
      chk("rst_err_count", {24'b0, err_count}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_bresp", {30'b0, bus.bresp}, 32'd0);
      chk("rst_rresp", {30'b0, bus.rresp}, 32'd0);
      resetn = 1'b1;
      tick();
      chk("rst_awready", {31'b0, bus.awready}, 32'd1);
      chk("rst_wready", {31'b0, bus.wready}, 32'd1);
      chk("rst_arready", {31'b0, bus.arready}, 32'd1);

      // AW first, W three cycles later.
      bus.awvalid = 1'b1; bus.awaddr = 32'h100;
      tick();
      bus.awvalid = 1'b0;
      chk("t1_awready_low", {31'b0, bus.awready}, 32'd0);
      chk("t1_wready_high", {31'b0, bus.wready}, 32'd1);
      tick(); tick();
      chk("t1_no_bvalid", {31'b0, bus.bvalid}, 32'd0);
      bus.wvalid = 1'b1; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'b1111;
      tick();
      bus.wvalid = 1'b0;
      chk("t1_bvalid_pre", {31'b0, bus.bvalid}, 32'd0);
      tick();
      chk("t1_bvalid", {31'b0, bus.bvalid}, 32'd1);
      chk("t1_bresp", {30'b0, bus.bresp}, 32'd0);
      ack_b();
      do_read("t1_rd", 32'h100, 32'hDEAD_BEEF, RESP_OKAY);

      // W before AW, single byte lane.
      bus.wvalid = 1'b1; bus.wdata = 32'h0000_00AA; bus.wstrb = 4'b0001;
      tick();
      bus.wvalid = 1'b0;
      chk("t2_wready_low", {31'b0, bus.wready}, 32'd0);
      chk("t2_awready_high", {31'b0, bus.awready}, 32'd1);
      tick();
      bus.awvalid = 1'b1; bus.awaddr = 32'h100;
      tick();
      bus.awvalid = 1'b0;
      chk("t2_bvalid_pre", {31'b0, bus.bvalid}, 32'd0);
      tick();
      chk("t2_bvalid", {31'b0, bus.bvalid}, 32'd1);
      chk("t2_bresp", {30'b0, bus.bresp}, 32'd0);
      ack_b();
      do_read("t2_rd", 32'h100, 32'hDEAD_BEAA, RESP_OKAY);

      // Console byte.
      chk("t3_console_idle", {31'b0, console_valid}, 32'd0);
      do_write(32'h1000_0000, 32'h0000_0041, 4'b1111);
      chk("t3_console_valid", {31'b0, console_valid}, 32'd1);
      chk("t3_console_data", {24'b0, console_data}, 32'h41);
      chk("t3_bresp", {30'b0, bus.bresp}, 32'd0);
      ack_b();
      chk("t3_console_pulse_end", {31'b0, console_valid}, 32'd0);
      do_read("t3_rd_console", 32'h1000_0000, 32'h0, RESP_SLVERR);
      chk("t3_err_count", {24'b0, err_count}, 32'd1);

      // Out-of-range write and read.
      resetn = 1'b0; #1; resetn = 1'b1; tick();
      do_write(32'h0001_0000, 32'h1234_5678, 4'b1111);
      chk("t4_bresp", {30'b0, bus.bresp}, {30'b0, RESP_SLVERR});
      ack_b();
      chk("t4_err_after_wr", {24'b0, err_count}, 32'd1);
      do_read("t4_rd", 32'h2000_0000, 32'h0, RESP_SLVERR);
      chk("t4_err_count", {24'b0, err_count}, 32'd2);
      do_read("t4_rd_keep", 32'h100, 32'hDEAD_BEAA, RESP_OKAY);

      // Both response channels stalled for 5 cycles.
      do_write(32'h200, 32'h1234_5678, 4'b1111);
      bus.arvalid = 1'b1; bus.araddr = 32'h100;
      tick();
      bus.arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t5_bvalid", {31'b0, bus.bvalid}, 32'd1);
         chk("t5_rvalid", {31'b0, bus.rvalid}, 32'd1);
         chk("t5_bresp", {30'b0, bus.bresp}, 32'd0);
         chk("t5_rresp", {30'b0, bus.rresp}, 32'd0);
         chk("t5_rdata", bus.rdata, 32'hDEAD_BEAA);
         chk("t5_awready", {31'b0, bus.awready}, 32'd0);
         chk("t5_wready", {31'b0, bus.wready}, 32'd0);
         chk("t5_arready", {31'b0, bus.arready}, 32'd0);
         tick();
      end
      bus.bready = 1'b1; bus.rready = 1'b1;
      tick();
      bus.bready = 1'b0; bus.rready = 1'b0;
      chk("t5_bvalid_clr", {31'b0, bus.bvalid}, 32'd0);
      chk("t5_rvalid_clr", {31'b0, bus.rvalid}, 32'd0);
      do_read("t5_rd", 32'h200, 32'h1234_5678, RESP_OKAY);

      // Read and write commit to the same word in one cycle.
      bus.awvalid = 1'b1; bus.awaddr = 32'h100;
      bus.wvalid = 1'b1; bus.wdata = 32'h1111_1111; bus.wstrb = 4'b1111;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      bus.arvalid = 1'b1; bus.araddr = 32'h100;
      tick();
      bus.arvalid = 1'b0;
      chk("t6_bvalid", {31'b0, bus.bvalid}, 32'd1);
      chk("t6_rvalid", {31'b0, bus.rvalid}, 32'd1);
      chk("t6_rdata_old", bus.rdata, 32'hDEAD_BEAA);
      bus.bready = 1'b1; bus.rready = 1'b1;
      tick();
      bus.bready = 1'b0; bus.rready = 1'b0;
      do_read("t6_rd_new", 32'h100, 32'h1111_1111, RESP_OKAY);

      // Reset while a write response is pending.
      do_write(32'h104, 32'h5555_5555, 4'b1111);
      chk("t7_err_before", {24'b0, err_count}, 32'd2);
      resetn = 1'b0;
      #1;
      chk("t7_bvalid_rst", {31'b0, bus.bvalid}, 32'd0);
      chk("t7_err_rst", {24'b0, err_count}, 32'd0);
      tick();
      resetn = 1'b1;
      tick();
      chk("t7_awready", {31'b0, bus.awready}, 32'd1);
      do_read("t7_rd_100", 32'h100, 32'h1111_1111, RESP_OKAY);

      // err_count saturation.
      for (int i = 0; i < 258; i++) begin
         do_read("t8_bad_rd", 32'h2000_0000, 32'h0, RESP_SLVERR);
      end
      chk("t8_err_sat", {24'b0, err_count}, 32'd255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
